// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and widths for the data-memory responder
package mem_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam int WORD_W   = 32;
    localparam int MAX_WAIT = 15;
endpackage

// File: rtl/word_ram.sv
// word_ram: DEPTH x WORD_W storage, synchronous write, registered read, no reset
module word_ram
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data-port target serving word reads/writes after
// WAIT_STATES wait cycles, with a one-cycle memReady/memError completion pulse.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataAddress,
    input  logic [31:0] dataIn,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] dataOut,
    output logic        memReady,
    output logic        memError
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [31:0] LAST_OFF = 32'(4 * DEPTH - 4);
    localparam logic [3:0] WAIT_LD = 4'((WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES);
    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [31:0] addr, wdata, off;
    logic rd_req, wr_req, both_req;
    logic req, fire, bad, dout_vld;
    logic [WORD_W-1:0] ram_q;
    assign req = MemRead | MemWrite;
    // unsigned subtraction makes addresses below BASE_ADDR wrap and fail the range test
    assign off = addr - BASE_ADDR;
    assign bad = (addr[1:0] != 2'd0) | (off > LAST_OFF) | both_req;
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        fire = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nx = req ? ST_WAIT : ST_IDLE;
                cnt_nx = req ? WAIT_LD : cnt;
            end
            ST_WAIT: begin
                if (!req) state_nx = ST_IDLE;
                else if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
                else begin
                    fire = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt <= 4'd0;
            addr <= 32'd0;
            wdata <= 32'd0;
            rd_req <= 1'b0;
            wr_req <= 1'b0;
            both_req <= 1'b0;
            memReady <= 1'b0;
            memError <= 1'b0;
            dout_vld <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (state == ST_IDLE && req) begin
                addr <= dataAddress;
                wdata <= dataIn;
                rd_req <= MemRead;
                wr_req <= MemWrite;
                both_req <= MemRead & MemWrite;
            end
            memReady <= fire;
            memError <= fire & bad;
            dout_vld <= (fire & bad) ? 1'b0 : (fire & rd_req) ? 1'b1 : dout_vld;
        end
    end
    // the RAM read register holds the last good read; dout_vld gates it to zero after reset or an error
    assign dataOut = dout_vld ? ram_q : 32'd0;
    word_ram #(.DEPTH(DEPTH)) u_ram (
        .clk  (clk),
        .we   (fire & wr_req & ~bad),
        .re   (fire & rd_req & ~bad),
        .addr (off[IW+1:2]),
        .wdata(wdata),
        .rdata(ram_q)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven directed checks plus abort/reset sequences
module tb_data_mem_responder;
    import mem_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] dataAddress = '0, dataIn = '0, dataOut;
    logic MemRead = 1'b0, MemWrite = 1'b0, memReady, memError;
    int checks = 0, errors = 0;
    data_mem_responder #(.BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .dataAddress(dataAddress), .dataIn(dataIn),
        .MemRead(MemRead), .MemWrite(MemWrite), .dataOut(dataOut),
        .memReady(memReady), .memError(memError)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic rd, wr;
        logic [31:0] addr, data, exp_dout;
        logic exp_err;
    } vec_t;
    vec_t v[12];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic wait_rdy(input int start, output int lat);
        lat = start;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!memReady && lat < 20);
    endtask
    task automatic txn(input string name, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_dout, input logic exp_err);
        int lat;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; dataAddress = a; dataIn = d;
        wait_rdy(0, lat);
        MemRead = 1'b0; MemWrite = 1'b0;
        chk({name, " latency"}, 32'(lat), 32'd4);
        chk({name, " dataOut"}, dataOut, exp_dout);
        chk({name, " memError"}, 32'(memError), 32'(exp_err));
        @(posedge clk); #1;
        chk({name, " pulse width"}, 32'(memReady), 32'd0);
    endtask
    initial begin
        int lat;
        v[0]  = '{1'b0, 1'b1, 32'h10,        32'hDEADBEEF, 32'h0,        1'b0};
        v[1]  = '{1'b1, 1'b0, 32'h10,        32'h0,        32'hDEADBEEF, 1'b0};
        v[2]  = '{1'b0, 1'b1, 32'h14,        32'h00000055, 32'hDEADBEEF, 1'b0};
        v[3]  = '{1'b1, 1'b0, 32'h12,        32'h0,        32'h0,        1'b1};
        v[4]  = '{1'b1, 1'b0, 32'h10,        32'h0,        32'hDEADBEEF, 1'b0};
        v[5]  = '{1'b1, 1'b0, 32'h1000,      32'h0,        32'h0,        1'b1};
        v[6]  = '{1'b0, 1'b1, 32'hFFC,       32'hA5A5A5A5, 32'h0,        1'b0};
        v[7]  = '{1'b1, 1'b0, 32'hFFC,       32'h0,        32'hA5A5A5A5, 1'b0};
        v[8]  = '{1'b1, 1'b1, 32'h10,        32'h0,        32'h0,        1'b1};
        v[9]  = '{1'b1, 1'b0, 32'hFFFFFFFC,  32'h0,        32'h0,        1'b1};
        v[10] = '{1'b1, 1'b0, 32'h10,        32'h0,        32'hDEADBEEF, 1'b0};
        v[11] = '{1'b0, 1'b1, 32'h20,        32'h11111111, 32'hDEADBEEF, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        chk("reset dataOut", dataOut, 32'h0);
        chk("reset memReady", 32'(memReady), 32'd0);
        chk("reset memError", 32'(memError), 32'd0);
        @(negedge clk) reset = 1'b0;
        foreach (v[i]) txn($sformatf("vec%0d", i), v[i].rd, v[i].wr, v[i].addr, v[i].data, v[i].exp_dout, v[i].exp_err);
        // address moves during WAIT; the latched 0x10 must still be served
        @(negedge clk);
        MemRead = 1'b1; dataAddress = 32'h10;
        @(posedge clk); #1;
        dataAddress = 32'h14;
        wait_rdy(1, lat);
        MemRead = 1'b0;
        chk("latched addr latency", 32'(lat), 32'd4);
        chk("latched addr dataOut", dataOut, 32'hDEADBEEF);
        chk("latched addr memError", 32'(memError), 32'd0);
        // write dropped after one WAIT cycle aborts with no pulse and no write
        @(negedge clk);
        MemWrite = 1'b1; dataAddress = 32'h20; dataIn = 32'h12345678;
        @(posedge clk); @(posedge clk);
        @(negedge clk) MemWrite = 1'b0;
        lat = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (memReady) lat++;
        end
        chk("abort no pulse", 32'(lat), 32'd0);
        chk("abort idle", 32'(dut.state), 32'(ST_IDLE));
        txn("abort readback", 1'b1, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);
        // async reset during WAIT of a write clears outputs with no clock edge
        @(negedge clk);
        MemWrite = 1'b1; dataAddress = 32'h10; dataIn = 32'h0;
        @(posedge clk); #1;
        #3 reset = 1'b1;
        #1;
        chk("async rst dataOut", dataOut, 32'h0);
        chk("async rst memReady", 32'(memReady), 32'd0);
        chk("async rst state", 32'(dut.state), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0; MemWrite = 1'b0;
        txn("post reset read", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder, the target end of the CPU data port (MemRead/MemWrite/dataAddress/dataIn/dataOut).
- Serves word reads and writes from an internal RAM after a programmable number of wait states.
- Signals completion with a one-cycle memReady pulse and reports bad requests on memError.
- Sits between the CPU data port and the word storage; gives the datapath a realistic, non-zero-latency memory target.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- DEPTH, 1024, number of 32-bit words.
- WAIT_STATES, 2, extra cycles between accept and completion (0..15).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- dataAddress  input  32  byte address from CPU.
- dataIn  input  32  write data from CPU (the CPU's register-file read port 2).
- MemRead  input  1  read request.
- MemWrite  input  1  write request.
- dataOut  output  32  read data to CPU, registered.
- memReady  output  1  one-cycle completion pulse.
- memError  output  1  one-cycle error flag, coincident with memReady.

Behaviour:
- Reset is asynchronous and active-high.
  - On assertion: state=IDLE, counter=0, dataOut=0, memReady=0, memError=0, latched request cleared.
  - RAM contents are not cleared and are retained across reset.
  - Reset mid-operation aborts the request; no write is committed.
- FSM states:
  - IDLE: at posedge, if MemRead|MemWrite, latch address, data and request type; load counter=WAIT_STATES; go to WAIT. Otherwise stay.
  - WAIT:
    - If both MemRead and MemWrite are low at a posedge: abort, go to IDLE, no pulse, no write.
    - Else if counter!=0: decrement.
    - Else (counter==0): perform the access, set memReady=1 (and memError if the request is bad), go to DONE.
  - DONE: at next posedge, clear memReady/memError and go to IDLE unconditionally.
- Latency:
  - memReady is high in the cycle following posedge accept+WAIT_STATES+1.
  - A held request after DONE is accepted again in IDLE as a new request (minimum 1 idle cycle between transactions).
  - The initiator must drop its request while memReady is high.
- Latched values:
  - Address, data and type are latched at accept.
  - Changes to dataAddress/dataIn during WAIT are ignored; only request drop (abort) is observed.
- Error conditions, evaluated on latched values:
  - address[1:0]!=0;
  - (address-BASE_ADDR) outside [0, 4*DEPTH-4], computed as 32-bit unsigned subtraction so addresses below BASE wrap and fail;
  - both MemRead and MemWrite asserted at accept.
- On error:
  - no RAM access;
  - memError=1 together with memReady;
  - dataOut=0.
- Read: dataOut <= RAM[(address-BASE_ADDR)>>2] at the completion edge. dataOut then holds until the next completed read or an error.
- Write:
  - RAM[index] <= latched data at the completion edge;
  - dataOut unchanged.
- Index width: $clog2(DEPTH). Counter width: 4 bits.

Decomposition:
- Shared package `mem_pkg`:
  - state encoding (ST_IDLE=2'd0, ST_WAIT=2'd1, ST_DONE=2'd2);
  - WORD_W=32;
  - MAX_WAIT=15.
- One natural sub-module `word_ram`:
  - DEPTH x 32 array;
  - synchronous write enable;
  - synchronous registered read;
  - no reset.
- The FSM, address check and counter stay in data_mem_responder.

Test Plan:
- WAIT_STATES=2: MemWrite addr 0x10 data 0xDEADBEEF, then MemRead addr 0x10 -> memReady pulse 3 cycles after each accept edge; dataOut=0xDEADBEEF; memError=0.
- Read accepted at 0x10, then dataAddress changed to 0x14 during WAIT -> still returns 0xDEADBEEF.
- MemRead addr 0x12 (misaligned) and MemRead addr 0x1000 (beyond DEPTH=1024) -> memReady=1 with memError=1; dataOut=0; re-read of 0x10 still 0xDEADBEEF.
- MemRead=MemWrite=1 addr 0x10 data 0x0 -> memError=1; subsequent read of 0x10 returns 0xDEADBEEF.
- Write 0x20 data 0x11111111 completes; then MemWrite 0x20 data 0x12345678 dropped after one WAIT cycle -> no memReady; FSM in IDLE next cycle; read 0x20 returns 0x11111111.
- reset asserted between clock edges during WAIT of a write to 0x10 (data 0x0) -> outputs 0 immediately without a clock edge; after release, read 0x10 returns 0xDEADBEEF.
